psr_cond_unit: RTL
==================

PSR_COND_UNIT -- requirements
Module: psr_cond_unit

Interface
REQ-001 SHALL have parameter P_RESET_FLAGS, default 5'b00000, the flag register value loaded on reset.
REQ-002 SHALL have port I_CLK, input, 1 bit, the single clock; all state updates on the rising edge.
REQ-003 SHALL have port I_NRESET, input, 1 bit, the reset; asynchronous and active-low.
REQ-004 SHALL have port I_STATUS_WE, input, 1 bit, the ALU status write strobe.
REQ-005 SHALL have port I_STATUS, input, 5 bits, the ALU status vector: bit 0 C, bit 1 L, bit 2 F, bit 3 Z, bit 4 N.
REQ-006 SHALL have port I_STATUS_MASK, input, 5 bits, the per-bit update enable applied with I_STATUS_WE.
REQ-007 SHALL have port I_COND_VALID, input, 1 bit, a condition query request.
REQ-008 SHALL have port I_COND, input, 4 bits, the CR16 condition code of the query.
REQ-009 SHALL have port O_COND_READY, output, 1 bit, the unit accepts a query this cycle.
REQ-010 SHALL have port O_TAKEN_VALID, output, 1 bit, a query result is pending.
REQ-011 SHALL have port O_TAKEN, output, 1 bit, the result value: condition met.
REQ-012 SHALL have port I_TAKEN_READY, input, 1 bit, the consumer accepts the result.
REQ-013 SHALL have port O_FLAGS, output, 5 bits, the current flag register.

Function
REQ-014 SHALL update flag bit i on each edge with I_STATUS_WE=1 and I_STATUS_MASK[i]=1 to I_STATUS[i]; flag bits with the mask bit clear hold.
REQ-015 SHALL decode conditions as follows: 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 HI L; 5 LS !L; 6 GT N; 7 LE !N; 8 FS F; 9 FC !F; 10 LO !L&!Z; 11 HS L|Z; 12 LT !N&!Z; 13 GE N|Z; 14 UC 1; 15 never 0.
REQ-016 SHALL drive O_COND_READY = !O_TAKEN_VALID | I_TAKEN_READY, combinationally.
REQ-017 SHALL accept a query on an edge where I_COND_VALID & O_COND_READY, and on that edge register O_TAKEN and set O_TAKEN_VALID, giving 1-cycle latency.
REQ-018 SHALL evaluate a query accepted in the same cycle as a status write against the forwarded post-write flags.
REQ-019 SHALL hold O_TAKEN and O_TAKEN_VALID stable while O_TAKEN_VALID=1 and I_TAKEN_READY=0.
REQ-020 SHALL clear O_TAKEN_VALID on a result handshake with no new query, and replace the result in the same cycle when a new query is accepted on the handshake, without a bubble.
REQ-021 SHALL implement the result path as a 2-state FSM: IDLE (valid=0) goes to FULL on accept; FULL goes to IDLE on a handshake with no accept; FULL stays FULL on a stall or on handshake plus accept.
REQ-022 SHALL ignore I_COND when I_COND_VALID=0, and flag updates SHALL proceed independently of result-path stalls.

Reset
REQ-023 SHALL, while I_NRESET=0, force the flags to P_RESET_FLAGS, O_TAKEN_VALID=0, O_TAKEN=0, FSM state IDLE, and the shadow register (when compiled in) to 0, regardless of the clock.
REQ-024 SHALL discard any pending result on reset mid-operation; O_COND_READY SHALL read 1 during and after reset.

Configuration
REQ-025 SHALL, with macro PSR_SHADOW_EN defined, add inputs I_SAVE and I_RESTORE (1 bit each): I_SAVE copies the flags into a shadow register; I_RESTORE loads the flags from the shadow register.
REQ-026 SHALL give priority with PSR_SHADOW_EN defined as I_RESTORE over I_STATUS_WE; I_SAVE captures the pre-edge flags; query forwarding follows the winning source.
REQ-027 SHALL, without PSR_SHADOW_EN, omit those ports and the shadow register entirely.

Structure
REQ-028 SHALL place the status bit index constants and the 16 condition code constants in shared package cr16_pkg.
REQ-029 SHALL implement condition decoding in combinational sub-module cond_eval (inputs flags and code; output met), instantiated once.

Verification
REQ-030 SHALL cover: reset, then query EQ -> O_TAKEN_VALID=1 the next cycle with O_TAKEN=0 and O_FLAGS=5'b00000.
REQ-031 SHALL cover: STATUS_WE with status 5'b01000 and mask 5'b11111, same-cycle query EQ -> O_TAKEN=1 (forwarded).
REQ-032 SHALL cover: flags 5'b10001, mask 5'b01000 writing status 5'b00000 -> flags 5'b10001 (Z already 0, other bits held).
REQ-033 SHALL cover: hold I_TAKEN_READY=0 for 3 cycles after query CS with C=1 -> O_TAKEN=1 held and O_COND_READY=0; then READY=1 with a new query UC -> back-to-back results 1, 1.
REQ-034 SHALL cover: all 16 codes over all 32 flag values -> result matches the REQ-015 table.
REQ-035 SHALL cover: I_NRESET pulsed low mid-stall -> O_TAKEN_VALID=0 immediately and flags = P_RESET_FLAGS; with PSR_SHADOW_EN, save 5'b10101, overwrite, restore -> O_FLAGS=5'b10101.

Source files
------------

// File: rtl/cr16_pkg.sv
// Shared CR16 definitions: status-bit positions, condition codes,
// result-path FSM states and the masked flag-merge helper.
package cr16_pkg;

  localparam int unsigned NUM_FLAGS = 5;

  // Bit positions inside the flag / ALU status vector.
  localparam int unsigned FLAG_C = 0;
  localparam int unsigned FLAG_L = 1;
  localparam int unsigned FLAG_F = 2;
  localparam int unsigned FLAG_Z = 3;
  localparam int unsigned FLAG_N = 4;

  // CR16 condition codes.
  typedef enum logic [3:0] {
    COND_EQ = 4'd0,
    COND_NE = 4'd1,
    COND_CS = 4'd2,
    COND_CC = 4'd3,
    COND_HI = 4'd4,
    COND_LS = 4'd5,
    COND_GT = 4'd6,
    COND_LE = 4'd7,
    COND_FS = 4'd8,
    COND_FC = 4'd9,
    COND_LO = 4'd10,
    COND_HS = 4'd11,
    COND_LT = 4'd12,
    COND_GE = 4'd13,
    COND_UC = 4'd14,
    COND_NV = 4'd15
  } cond_e;

  // Result-path states: IDLE has no pending result, FULL holds one.
  typedef enum logic {
    RES_IDLE = 1'b0,
    RES_FULL = 1'b1
  } res_state_e;

  // Replace only the bits selected by mask with the new status bits.
  function automatic logic [NUM_FLAGS-1:0] merge_flags(
    input logic [NUM_FLAGS-1:0] cur,
    input logic [NUM_FLAGS-1:0] src,
    input logic [NUM_FLAGS-1:0] mask
  );
    return (cur & ~mask) | (src & mask);
  endfunction

endpackage

// File: rtl/psr_cond_unit_if.sv
// Status-write / condition-query / result bus of psr_cond_unit.
// Optional macro PSR_SHADOW_EN adds the I_SAVE / I_RESTORE controls.
interface psr_cond_unit_if
  import cr16_pkg::*;
;
`ifdef PSR_SHADOW_EN
  logic                 I_SAVE;
  logic                 I_RESTORE;
`endif
  logic                 I_STATUS_WE;
  logic [NUM_FLAGS-1:0] I_STATUS;
  logic [NUM_FLAGS-1:0] I_STATUS_MASK;
  logic                 I_COND_VALID;
  logic [3:0]           I_COND;
  logic                 O_COND_READY;
  logic                 O_TAKEN_VALID;
  logic                 O_TAKEN;
  logic                 I_TAKEN_READY;
  logic [NUM_FLAGS-1:0] O_FLAGS;

  // Requester / consumer side.
  modport master (
`ifdef PSR_SHADOW_EN
    output I_SAVE,
    output I_RESTORE,
`endif
    output I_STATUS_WE,
    output I_STATUS,
    output I_STATUS_MASK,
    output I_COND_VALID,
    output I_COND,
    input  O_COND_READY,
    input  O_TAKEN_VALID,
    input  O_TAKEN,
    output I_TAKEN_READY,
    input  O_FLAGS
  );

  // Flag unit side.
  modport slave (
`ifdef PSR_SHADOW_EN
    input  I_SAVE,
    input  I_RESTORE,
`endif
    input  I_STATUS_WE,
    input  I_STATUS,
    input  I_STATUS_MASK,
    input  I_COND_VALID,
    input  I_COND,
    output O_COND_READY,
    output O_TAKEN_VALID,
    output O_TAKEN,
    input  I_TAKEN_READY,
    output O_FLAGS
  );

endinterface

// File: rtl/cond_eval.sv
// Combinational CR16 condition decoder: met = condition(code) over flags.
module cond_eval
  import cr16_pkg::*;
(
  input  logic [NUM_FLAGS-1:0] flags,
  input  logic [3:0]           code,
  output logic                 met
);

  logic c_s;
  logic l_s;
  logic f_s;
  logic z_s;
  logic n_s;

  assign c_s = flags[FLAG_C];
  assign l_s = flags[FLAG_L];
  assign f_s = flags[FLAG_F];
  assign z_s = flags[FLAG_Z];
  assign n_s = flags[FLAG_N];

  // Decode the condition code against the flag bits.
  always_comb begin
    met = 1'b0;
    case (code)
      COND_EQ: met = z_s;
      COND_NE: met = ~z_s;
      COND_CS: met = c_s;
      COND_CC: met = ~c_s;
      COND_HI: met = l_s;
      COND_LS: met = ~l_s;
      COND_GT: met = n_s;
      COND_LE: met = ~n_s;
      COND_FS: met = f_s;
      COND_FC: met = ~f_s;
      COND_LO: met = ~l_s & ~z_s;
      COND_HS: met = l_s | z_s;
      COND_LT: met = ~n_s & ~z_s;
      COND_GE: met = n_s | z_s;
      COND_UC: met = 1'b1;
      COND_NV: met = 1'b0;
      default: met = 1'b0;
    endcase
  end

endmodule

// File: rtl/psr_cond_unit.sv
// CR16 processor-status flag register with a valid/ready condition query
// port. Queries see the post-write flags of the same edge (forwarding).
// Optional macro PSR_SHADOW_EN adds a one-entry shadow copy of the flags
// (I_SAVE / I_RESTORE); restore wins over an ALU status write.
module psr_cond_unit
  import cr16_pkg::*;
#(
  parameter logic [NUM_FLAGS-1:0] P_RESET_FLAGS = 5'b00000
) (
  input logic            I_CLK,
  input logic            I_NRESET,
  psr_cond_unit_if.slave bus
);

  logic [NUM_FLAGS-1:0] flags_r;
  logic [NUM_FLAGS-1:0] flags_next_s;
  res_state_e           state_r;
  res_state_e           state_next_s;
  logic                 taken_r;
  logic                 taken_valid_s;
  logic                 cond_ready_s;
  logic                 accept_s;
  logic                 handshake_s;
  logic                 met_s;

`ifdef PSR_SHADOW_EN
  logic [NUM_FLAGS-1:0] shadow_r;

  // Next flag value: restore beats a status write, otherwise hold.
  always_comb begin
    flags_next_s = flags_r;
    if (bus.I_RESTORE) begin
      flags_next_s = shadow_r;
    end else if (bus.I_STATUS_WE) begin
      flags_next_s = merge_flags(flags_r, bus.I_STATUS, bus.I_STATUS_MASK);
    end else begin
      flags_next_s = flags_r;
    end
  end

  // Shadow copy captures the flags as they were before this edge.
  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      shadow_r <= {NUM_FLAGS{1'b0}};
    end else if (bus.I_SAVE) begin
      shadow_r <= flags_r;
    end else begin
      shadow_r <= shadow_r;
    end
  end
`else
  // Next flag value: masked status write, otherwise hold.
  always_comb begin
    flags_next_s = flags_r;
    if (bus.I_STATUS_WE) begin
      flags_next_s = merge_flags(flags_r, bus.I_STATUS, bus.I_STATUS_MASK);
    end else begin
      flags_next_s = flags_r;
    end
  end
`endif

  // Flag register; updates regardless of result-path stalls.
  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      flags_r <= P_RESET_FLAGS;
    end else begin
      flags_r <= flags_next_s;
    end
  end

  // Queries are evaluated on the forwarded (post-write) flags.
  cond_eval u_cond_eval (
    .flags (flags_next_s),
    .code  (bus.I_COND),
    .met   (met_s)
  );

  assign cond_ready_s = ~taken_valid_s | bus.I_TAKEN_READY;
  assign accept_s     = bus.I_COND_VALID & cond_ready_s;
  assign handshake_s  = taken_valid_s & bus.I_TAKEN_READY;

  // Result-path state register.
  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      state_r <= RES_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Result-path next state: fill on accept, drain on a handshake with no refill.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      RES_IDLE: begin
        if (accept_s) begin
          state_next_s = RES_FULL;
        end else begin
          state_next_s = RES_IDLE;
        end
      end
      RES_FULL: begin
        if (handshake_s && !accept_s) begin
          state_next_s = RES_IDLE;
        end else begin
          state_next_s = RES_FULL;
        end
      end
      default: state_next_s = RES_IDLE;
    endcase
  end

  // Result-path outputs decoded from the state register.
  always_comb begin
    taken_valid_s = 1'b0;
    case (state_r)
      RES_IDLE: taken_valid_s = 1'b0;
      RES_FULL: taken_valid_s = 1'b1;
      default:  taken_valid_s = 1'b0;
    endcase
  end

  // Result value; replaced only when a new query is accepted.
  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      taken_r <= 1'b0;
    end else if (accept_s) begin
      taken_r <= met_s;
    end else begin
      taken_r <= taken_r;
    end
  end

  assign bus.O_COND_READY  = cond_ready_s;
  assign bus.O_TAKEN_VALID = taken_valid_s;
  assign bus.O_TAKEN       = taken_r;
  assign bus.O_FLAGS       = flags_r;

endmodule
